// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO interrupt controller: bus geometry and
// register index map.
package gpio_pkg;

  localparam int BUS_DW = 32;
  localparam int ADDR_W = 3;

  localparam logic [ADDR_W-1:0] GPIO_DOUT    = 3'd0;
  localparam logic [ADDR_W-1:0] GPIO_DIR     = 3'd1;
  localparam logic [ADDR_W-1:0] GPIO_DIN     = 3'd2;
  localparam logic [ADDR_W-1:0] GPIO_RISE_EN = 3'd3;
  localparam logic [ADDR_W-1:0] GPIO_FALL_EN = 3'd4;
  localparam logic [ADDR_W-1:0] GPIO_PEND    = 3'd5;

endpackage

// File: rtl/gpio_sync_edge.sv
// Single-channel input conditioner: metastability chain on the raw pad,
// one history flop behind it, and rise/fall pulses derived from the pair.
module gpio_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain_r;
  logic                   hist_r;

  // Shift the asynchronous pad through the synchroniser and keep last sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_r <= '0;
      hist_r  <= 1'b0;
    end else begin
      chain_r <= {chain_r[SYNC_STAGES-2:0], pin};
      hist_r  <= chain_r[SYNC_STAGES-1];
    end
  end

  assign sync = chain_r[SYNC_STAGES-1];
  assign rise = sync & ~hist_r;
  assign fall = ~sync & hist_r;

endmodule

// File: rtl/gpio_irq_ctrl.sv
// Bus-mapped GPIO block: per-channel direction and output value registers,
// synchronised input readback and edge-triggered, write-1-to-clear
// interrupt pending bits folded into one level interrupt.
module gpio_irq_ctrl
  import gpio_pkg::*;
#(
  parameter int NCH         = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_we,
  input  logic              bus_re,
  input  logic [BUS_DW-1:0] bus_wdata,
  output logic [BUS_DW-1:0] bus_rdata,
  input  logic [NCH-1:0]    pin_in,
  output logic [NCH-1:0]    pin_out,
  output logic [NCH-1:0]    pin_oe,
  output logic              irq
);

  logic [NCH-1:0]    dout_r;
  logic [NCH-1:0]    dir_r;
  logic [NCH-1:0]    rise_en_r;
  logic [NCH-1:0]    fall_en_r;
  logic [NCH-1:0]    pend_r;
  logic [BUS_DW-1:0] bus_rdata_r;

  logic [NCH-1:0]    din_s;
  logic [NCH-1:0]    rise_s;
  logic [NCH-1:0]    fall_s;
  logic [NCH-1:0]    set_s;
  logic [NCH-1:0]    clr_s;
  logic [NCH-1:0]    pend_next_s;
  logic [BUS_DW-1:0] rdata_s;
  logic              unused_wdata_s;

  // Upper write-data bits beyond NCH are deliberately discarded.
  assign unused_wdata_s = ^bus_wdata;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    gpio_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
      .clk  (clk),
      .rst  (rst),
      .pin  (pin_in[i]),
      .sync (din_s[i]),
      .rise (rise_s[i]),
      .fall (fall_s[i])
    );
  end

  // Writable configuration registers; PEND is handled separately (W1C).
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_r    <= '0;
      dir_r     <= '0;
      rise_en_r <= '0;
      fall_en_r <= '0;
    end else if (bus_we) begin
      case (bus_addr)
        GPIO_DOUT:    dout_r    <= bus_wdata[NCH-1:0];
        GPIO_DIR:     dir_r     <= bus_wdata[NCH-1:0];
        GPIO_RISE_EN: rise_en_r <= bus_wdata[NCH-1:0];
        GPIO_FALL_EN: fall_en_r <= bus_wdata[NCH-1:0];
        default: begin
          dout_r    <= dout_r;
          dir_r     <= dir_r;
          rise_en_r <= rise_en_r;
          fall_en_r <= fall_en_r;
        end
      endcase
    end else begin
      dout_r    <= dout_r;
      dir_r     <= dir_r;
      rise_en_r <= rise_en_r;
      fall_en_r <= fall_en_r;
    end
  end

  // Pending update: enabled edges this cycle set, W1C clears, set dominates.
  always_comb begin
    set_s       = (rise_s & rise_en_r) | (fall_s & fall_en_r);
    clr_s       = '0;
    if (bus_we && (bus_addr == GPIO_PEND)) begin
      clr_s = bus_wdata[NCH-1:0];
    end else begin
      clr_s = '0;
    end
    pend_next_s = (pend_r & ~clr_s) | set_s;
  end

  // Pending register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r <= '0;
    end else begin
      pend_r <= pend_next_s;
    end
  end

  // Read mux over current (pre-write) register state, zero-extended.
  always_comb begin
    rdata_s = '0;
    case (bus_addr)
      GPIO_DOUT:    rdata_s[NCH-1:0] = dout_r;
      GPIO_DIR:     rdata_s[NCH-1:0] = dir_r;
      GPIO_DIN:     rdata_s[NCH-1:0] = din_s;
      GPIO_RISE_EN: rdata_s[NCH-1:0] = rise_en_r;
      GPIO_FALL_EN: rdata_s[NCH-1:0] = fall_en_r;
      GPIO_PEND:    rdata_s[NCH-1:0] = pend_r;
      default:      rdata_s = '0;
    endcase
  end

  // Registered read data, held between read strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_rdata_r <= '0;
    end else if (bus_re) begin
      bus_rdata_r <= rdata_s;
    end else begin
      bus_rdata_r <= bus_rdata_r;
    end
  end

  assign bus_rdata = bus_rdata_r;
  assign pin_out   = dout_r;
  assign pin_oe    = dir_r;
  assign irq       = |pend_r;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Directed bench for gpio_irq_ctrl: a register-access vector table plus
// hand-written edge/interrupt sequences, run on an 8-channel/2-stage and a
// 32-channel/3-stage instance.
module tb_gpio_irq_ctrl;
  import gpio_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  bus_addr;
  logic        bus_we;
  logic        bus_re;
  logic [31:0] bus_wdata;
  logic [31:0] pin_in;
  logic        sel;

  logic [31:0] rdata8, rdata32;
  logic [7:0]  pout8, poe8;
  logic [31:0] pout32, poe32;
  logic        irq8, irq32;

  logic [31:0] rd_s, pout_s, poe_s;
  logic        irq_s;

  int checks = 0;
  int errors = 0;
  int cur_nch = 8;

  always #5 clk = ~clk;

  gpio_irq_ctrl #(.NCH(8), .SYNC_STAGES(2)) u_dut8 (
    .clk(clk), .rst(rst), .bus_addr(bus_addr),
    .bus_we(bus_we & ~sel), .bus_re(bus_re & ~sel), .bus_wdata(bus_wdata),
    .bus_rdata(rdata8), .pin_in(pin_in[7:0]), .pin_out(pout8), .pin_oe(poe8),
    .irq(irq8)
  );

  gpio_irq_ctrl #(.NCH(32), .SYNC_STAGES(3)) u_dut32 (
    .clk(clk), .rst(rst), .bus_addr(bus_addr),
    .bus_we(bus_we & sel), .bus_re(bus_re & sel), .bus_wdata(bus_wdata),
    .bus_rdata(rdata32), .pin_in(pin_in), .pin_out(pout32), .pin_oe(poe32),
    .irq(irq32)
  );

  assign rd_s   = sel ? rdata32 : rdata8;
  assign pout_s = sel ? pout32 : {24'd0, pout8};
  assign poe_s  = sel ? poe32 : {24'd0, poe8};
  assign irq_s  = sel ? irq32 : irq8;

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp8;
    logic [31:0] exp32;
    string       name;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL nch%0d %s actual=0x%08h expected=0x%08h", cur_nch, name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_we    = 1'b1;
    @(negedge clk);
    bus_we    = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    bus_addr = a;
    bus_re   = 1'b1;
    @(negedge clk);
    bus_re   = 1'b0;
    d        = rd_s;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_suite(input int nch, input int ss);
    logic [31:0] mask;
    logic [31:0] rd;
    cur_nch = nch;
    mask    = (nch == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    sel     = (nch == 32);
    pin_in  = 32'd0;
    rst     = 1'b1;
    idle(2);
    rst     = 1'b0;

    // reset state
    for (int a = 0; a < 8; a++) begin
      bus_read(a[2:0], rd);
      check($sformatf("reset_read_%0d", a), rd, 32'd0);
    end
    check("reset_pin_oe", poe_s, 32'd0);
    check("reset_pin_out", pout_s, 32'd0);
    check("reset_irq", {31'd0, irq_s}, 32'd0);

    // direct pad drive
    bus_write(GPIO_DIR, 32'h0000_000F);
    bus_write(GPIO_DOUT, 32'h0000_00A5);
    check("pin_oe", poe_s, 32'h0000_000F);
    check("pin_out", pout_s, 32'h0000_00A5);

    // register access table
    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        bus_write(tbl[i].addr, tbl[i].wdata);
      end else begin
        bus_read(tbl[i].addr, rd);
        check(tbl[i].name, rd, sel ? tbl[i].exp32 : tbl[i].exp8);
      end
    end

    // rise latency on channel 0
    bus_write(GPIO_RISE_EN, 32'h0000_0001);
    pin_in[0] = 1'b1;
    for (int i = 1; i <= ss + 1; i++) begin
      @(negedge clk);
      check($sformatf("irq_latency_edge%0d", i - 1), {31'd0, irq_s},
            (i <= ss) ? 32'd0 : 32'd1);
    end
    bus_read(GPIO_DIN, rd);
    check("din_ch0", rd, 32'h0000_0001);
    bus_read(GPIO_PEND, rd);
    check("pend_rise", rd, 32'h0000_0001);

    // fall with FALL_EN=0 leaves PEND alone
    pin_in[0] = 1'b0;
    idle(ss + 3);
    bus_read(GPIO_PEND, rd);
    check("pend_fall_disabled", rd, 32'h0000_0001);

    // W1C bit by bit
    bus_write(GPIO_RISE_EN, 32'h0000_0003);
    pin_in[1] = 1'b1;
    idle(ss + 2);
    bus_read(GPIO_PEND, rd);
    check("pend_two", rd, 32'h0000_0003);
    bus_write(GPIO_PEND, 32'h0000_0001);
    bus_read(GPIO_PEND, rd);
    check("pend_w1c_bit0", rd, 32'h0000_0002);
    check("irq_still_set", {31'd0, irq_s}, 32'd1);
    bus_write(GPIO_PEND, 32'h0000_0000);
    bus_read(GPIO_PEND, rd);
    check("pend_write0_noop", rd, 32'h0000_0002);
    bus_write(GPIO_PEND, 32'h0000_0002);
    check("irq_cleared", {31'd0, irq_s}, 32'd0);

    // set wins over W1C; concurrent read sees pre-clear value
    pin_in[0] = 1'b1;
    idle(ss + 2);
    bus_read(GPIO_PEND, rd);
    check("pend_rearm", rd, 32'h0000_0001);
    pin_in[0] = 1'b0;
    idle(ss + 2);
    pin_in[0] = 1'b1;
    idle(ss);
    bus_addr = GPIO_PEND; bus_wdata = 32'h0000_0001;
    bus_we = 1'b1; bus_re = 1'b1;
    @(negedge clk);
    bus_we = 1'b0; bus_re = 1'b0;
    check("collide_read_old", rd_s, 32'h0000_0001);
    bus_read(GPIO_PEND, rd);
    check("collide_set_wins", rd, 32'h0000_0001);
    bus_addr = GPIO_PEND; bus_wdata = 32'h0000_0001;
    bus_we = 1'b1; bus_re = 1'b1;
    @(negedge clk);
    bus_we = 1'b0; bus_re = 1'b0;
    check("w1c_read_preclear", rd_s, 32'h0000_0001);
    bus_read(GPIO_PEND, rd);
    check("w1c_after", rd, 32'd0);
    check("irq_after_w1c", {31'd0, irq_s}, 32'd0);

    // simultaneous write and read of DOUT
    bus_addr = GPIO_DOUT; bus_wdata = 32'h0000_005A;
    bus_we = 1'b1; bus_re = 1'b1;
    @(negedge clk);
    bus_we = 1'b0; bus_re = 1'b0;
    check("rd_pre_write", rd_s, 32'd0);
    check("pin_out_5a", pout_s, 32'h0000_005A);

    // mid-operation reset with pins held high through release
    pin_in = mask;
    rst    = 1'b1;
    @(negedge clk);
    check("midrst_pin_out", pout_s, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(ss + 3);
    bus_write(GPIO_RISE_EN, mask);
    idle(3);
    bus_read(GPIO_RISE_EN, rd);
    check("rise_en_all", rd, mask);
    bus_read(GPIO_PEND, rd);
    check("no_retro_pend", rd, 32'd0);
    check("no_retro_irq", {31'd0, irq_s}, 32'd0);
    pin_in = 32'd0;
  endtask

  initial begin
    rst = 1'b1; bus_addr = 3'd0; bus_we = 1'b0; bus_re = 1'b0;
    bus_wdata = 32'd0; pin_in = 32'd0; sel = 1'b0;

    tbl.push_back('{1'b0, GPIO_DIR,     32'd0,         32'h0000_000F, 32'h0000_000F, "rd_dir"});
    tbl.push_back('{1'b0, GPIO_DOUT,    32'd0,         32'h0000_00A5, 32'h0000_00A5, "rd_dout"});
    tbl.push_back('{1'b1, GPIO_DOUT,    32'hFFFF_FFFF, 32'd0,         32'd0,         "wr_dout_ones"});
    tbl.push_back('{1'b0, GPIO_DOUT,    32'd0,         32'h0000_00FF, 32'hFFFF_FFFF, "rd_dout_ones"});
    tbl.push_back('{1'b1, GPIO_DIR,     32'hFFFF_0000, 32'd0,         32'd0,         "wr_dir_hi"});
    tbl.push_back('{1'b0, GPIO_DIR,     32'd0,         32'd0,         32'hFFFF_0000, "rd_dir_hi"});
    tbl.push_back('{1'b1, 3'd6,         32'h1234_5678, 32'd0,         32'd0,         "wr_rsv6"});
    tbl.push_back('{1'b0, 3'd6,         32'd0,         32'd0,         32'd0,         "rd_rsv6"});
    tbl.push_back('{1'b1, 3'd7,         32'hFFFF_FFFF, 32'd0,         32'd0,         "wr_rsv7"});
    tbl.push_back('{1'b0, 3'd7,         32'd0,         32'd0,         32'd0,         "rd_rsv7"});
    tbl.push_back('{1'b1, GPIO_DIN,     32'hFFFF_FFFF, 32'd0,         32'd0,         "wr_din"});
    tbl.push_back('{1'b0, GPIO_DIN,     32'd0,         32'd0,         32'd0,         "rd_din_ro"});
    tbl.push_back('{1'b1, GPIO_RISE_EN, 32'h0000_003C, 32'd0,         32'd0,         "wr_rise_en"});
    tbl.push_back('{1'b0, GPIO_RISE_EN, 32'd0,         32'h0000_003C, 32'h0000_003C, "rd_rise_en"});
    tbl.push_back('{1'b1, GPIO_FALL_EN, 32'h8000_00C3, 32'd0,         32'd0,         "wr_fall_en"});
    tbl.push_back('{1'b0, GPIO_FALL_EN, 32'd0,         32'h0000_00C3, 32'h8000_00C3, "rd_fall_en"});
    tbl.push_back('{1'b1, GPIO_PEND,    32'hFFFF_FFFF, 32'd0,         32'd0,         "wr_pend_idle"});
    tbl.push_back('{1'b0, GPIO_PEND,    32'd0,         32'd0,         32'd0,         "rd_pend_idle"});
    tbl.push_back('{1'b1, GPIO_DIR,     32'd0,         32'd0,         32'd0,         "clr_dir"});
    tbl.push_back('{1'b1, GPIO_DOUT,    32'd0,         32'd0,         32'd0,         "clr_dout"});
    tbl.push_back('{1'b1, GPIO_RISE_EN, 32'd0,         32'd0,         32'd0,         "clr_rise_en"});
    tbl.push_back('{1'b1, GPIO_FALL_EN, 32'd0,         32'd0,         32'd0,         "clr_fall_en"});
    tbl.push_back('{1'b0, GPIO_DOUT,    32'd0,         32'd0,         32'd0,         "rd_dout_clr"});

    @(negedge clk);
    run_suite(8, 2);
    run_suite(32, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
